fifo_same_clock_lvl: RTL

Parametrised single-clock FIFO, successor to the basic same-clock FIFO used in the AXI/BRAM address and data paths.
- Adds exact fill-level output, runtime-programmable almost-full/almost-empty thresholds, synchronous flush and defined overflow/underflow handling.
- Output is first-word-fall-through: data_out is valid whenever nempty=1.
- Sits between AXI channel decoders and the memory-controller command/data sequencers.

---
 rtl/fifo_same_clock_lvl.sv | 106 ++++++++++
 1 files changed

// File: rtl/fifo_same_clock_lvl.sv
// Single-clock first-word-fall-through FIFO with exact fill level, programmable
// almost-full/almost-empty thresholds and flush. Define FIFO_SAME_CLOCK_ERR_EN for sticky ovfl/unfl flags.
module fifo_same_clock_lvl #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  we,
  input  logic                  re,
`ifdef FIFO_SAME_CLOCK_ERR_EN
  input  logic                  err_clr,
  output logic                  ovfl,
  output logic                  unfl,
`endif
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_DEPTH:0]   af_thresh,
  input  logic [DATA_DEPTH:0]   ae_thresh,
  output logic [DATA_DEPTH:0]   fill,
  output logic                  nempty,
  output logic                  full,
  output logic                  half_full,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int CAP_I = 1 << DATA_DEPTH;
  localparam logic [DATA_DEPTH:0] CAP  = (DATA_DEPTH+1)'(1) << DATA_DEPTH;
  localparam logic [DATA_DEPTH:0] HALF = CAP >> 1;

  logic [DATA_WIDTH-1:0] mem [CAP_I];
  logic [DATA_DEPTH-1:0] wr_ptr;
  logic [DATA_DEPTH-1:0] rd_ptr;
  logic                  clear;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_DEPTH:0]   next_fill;

  // Handshake: a write is taken when we=1 and the FIFO is not full, or is full
  // but a read frees the slot in the same cycle; a read is taken when re=1 and
  // nempty=1. Requests that are not taken leave all state untouched.
  assign clear     = !rst_n || flush;
  assign wr_ok     = we && (!full || re);
  assign rd_ok     = re && nempty;
  assign next_fill = fill + (DATA_DEPTH+1)'(wr_ok) - (DATA_DEPTH+1)'(rd_ok);

  // Asynchronous read of the head slot gives zero-latency fall-through.
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!clear && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      nempty       <= 1'b0;
      full         <= 1'b0;
      half_full    <= 1'b0;
      almost_full  <= (af_thresh == '0);
      almost_empty <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + DATA_DEPTH'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + DATA_DEPTH'(1);
      end
      // Flags come from next_fill so they always agree with the registered fill.
      fill         <= next_fill;
      nempty       <= (next_fill != '0);
      full         <= (next_fill == CAP);
      half_full    <= (next_fill >= HALF);
      almost_full  <= (next_fill >= af_thresh);
      almost_empty <= (next_fill <= ae_thresh);
    end
  end

`ifdef FIFO_SAME_CLOCK_ERR_EN
  // A set event outranks err_clr so an error in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (clear) begin
      ovfl <= 1'b0;
      unfl <= 1'b0;
    end else begin
      if (we && full && !re) begin
        ovfl <= 1'b1;
      end else if (err_clr) begin
        ovfl <= 1'b0;
      end
      if (re && !nempty) begin
        unfl <= 1'b1;
      end else if (err_clr) begin
        unfl <= 1'b0;
      end
    end
  end
`endif

endmodule
